// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD <-> excess-3 word converter.
package bcd_xs3_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Distance between a BCD code and its excess-3 code
  localparam logic [3:0] XS3_OFFSET = 4'd3;

  // Conversion direction encodings carried on the mode input
  localparam logic MODE_TO_XS3 = 1'b0;
  localparam logic MODE_TO_BCD = 1'b1;

endpackage

// File: rtl/bcd_xs3_converter_digit_addsub.sv
// Single 4-bit adder/subtractor shared by every digit of the word.
// Subtraction is a + ~b + 1, so carry_o = 1 means "no borrow" (a >= b).
module digit_addsub (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] full;

  // Two's-complement add/subtract with the carry kept as the fifth bit
  always_comb begin
    full    = {1'b0, a_i} + {1'b0, b_i ^ {4{sub_i}}} + {4'b0000, sub_i};
    sum_o   = full[3:0];
    carry_o = full[4];
  end

endmodule

// File: rtl/bcd_xs3_converter.sv
// Serial BCD <-> excess-3 converter: one digit per cycle through a single
// shared add/subtract unit, with a per-digit illegal-code mask.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for a word; in_ready high, last result held
//   CONVERT | one digit per cycle, digit 0 first, word shifting down
//   DONE    | result presented with out_valid until out_ready
module bcd_xs3_converter
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e               state_q, state_d;
  logic [4*DIGITS-1:0]  word_q, word_d;
  logic [DIGITS-1:0]    err_q, err_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 mode_q, mode_d;

  logic [3:0]           digit;
  logic [3:0]           result;
  logic                 carry;
  logic                 subtract;
  logic                 illegal;

  assign digit    = word_q[3:0];
  assign subtract = (mode_q == MODE_TO_BCD);

  digit_addsub u_addsub (
    .a_i     (digit),
    .b_i     (XS3_OFFSET),
    .sub_i   (subtract),
    .sum_o   (result),
    .carry_o (carry)
  );

  // Legality of the current source digit; a missing carry when subtracting
  // is a borrow, i.e. the digit was below 3
  always_comb begin
    if (mode_q == MODE_TO_XS3) begin
      illegal = (digit > 4'd9);
    end else begin
      illegal = !carry || (digit > 4'd12);
    end
  end

  // Next-state and datapath updates; the converted digit enters at the top
  // so that after DIGITS shifts the word is back in its original order
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    err_d   = err_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          mode_d  = mode;
          err_d   = '0;
          idx_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        word_d                  = word_q >> 4;
        word_d[4*DIGITS-1 -: 4] = result;
        err_d[idx_q]            = illegal;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_TO_XS3;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = word_q;
  assign out_err_mask = err_q;

endmodule

// File: tb/tb_bcd_xs3_converter.sv
// Directed bench for the BCD <-> excess-3 converter (DIGITS = 4) with a
// transaction-level reference model checked every cycle.
module tb_bcd_xs3_converter;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_xs3_converter #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err_mask (out_err_mask),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference: each digit converted with plain integer arithmetic
  task automatic model(input logic [15:0] d, input logic m,
                       output logic [15:0] r, output logic [3:0] msk);
    int v;
    r = '0;
    msk = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v = int'(d[4*i +: 4]);
      if (!m) begin
        r[4*i +: 4] = 4'((v + 3) % 16);
        msk[i]      = (v > 9);
      end else begin
        r[4*i +: 4] = 4'((v + 16 - 3) % 16);
        msk[i]      = (v < 3) || (v > 12);
      end
    end
  endtask

  // Reference state: a word in flight, edges elapsed since its acceptance,
  // its expected result, and the last delivered result held in IDLE
  logic        pend = 1'b0;
  int          elapsed = 0;
  logic [15:0] exp_data = '0;
  logic [3:0]  exp_mask = '0;
  logic [15:0] last_data = '0;
  logic [3:0]  last_mask = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      = 1'b0;
      elapsed   = 0;
      last_data = '0;
      last_mask = '0;
    end else begin
      chk("mon_in_ready", in_ready, !pend);
      chk("mon_busy", busy, pend);
      chk("mon_out_valid", out_valid, pend && (elapsed >= DIGITS));
      if (pend && (elapsed >= DIGITS)) begin
        chk("mon_out_data", out_data, exp_data);
        chk("mon_out_mask", out_err_mask, exp_mask);
      end
      if (!pend) begin
        chk("mon_idle_data", out_data, last_data);
        chk("mon_idle_mask", out_err_mask, last_mask);
      end
      if (!pend) begin
        if (in_valid) begin
          pend    = 1'b1;
          elapsed = 0;
          model(in_data, mode, exp_data, exp_mask);
        end
      end else if (elapsed >= DIGITS) begin
        if (out_ready) begin
          pend      = 1'b0;
          last_data = exp_data;
          last_mask = exp_mask;
        end
      end else begin
        elapsed++;
      end
    end
  end

  // Offer one word, wait for the result, stall hold cycles, then handshake
  task automatic send(input logic [15:0] d, input logic m, input int hold,
                      input logic [15:0] lit_data, input logic [3:0] lit_mask,
                      input string tag);
    int acc_cyc;
    bit seen;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd4);
    chk({tag, "_data"}, out_data, lit_data);
    chk({tag, "_mask"}, out_err_mask, lit_mask);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      in_data  = 16'(k * 16'h1111);
      mode     = ~k[0];
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_data"}, out_data, lit_data);
      chk({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_after_ready"}, in_ready, 1'b1);
    chk({tag, "_after_valid"}, out_valid, 1'b0);
    chk({tag, "_after_data"}, out_data, lit_data);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_mask", out_err_mask, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    send(16'h1234, 1'b0, 0, 16'h4567, 4'b0000, "to_xs3");
    send(16'h4567, 1'b1, 0, 16'h1234, 4'b0000, "to_bcd");
    send(16'h19A0, 1'b0, 0, 16'h4CD3, 4'b0010, "xs3_err");
    send(16'h0F33, 1'b1, 0, 16'hDC00, 4'b1100, "bcd_err");
    send(16'h9AF0, 1'b0, 5, 16'hCD23, 4'b0110, "stall");
    send(16'h2D3C, 1'b1, 1, 16'hFA09, 4'b1100, "bcd_edge");

    // Reset while digit 2 is being converted
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h1234; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_data", out_data, 16'h0000);
    chk("abort_out_mask", out_err_mask, 4'b0000);
    #2 rst_n = 1'b1;
    send(16'h0000, 1'b0, 0, 16'h3333, 4'b0000, "post_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/bcd_xs3_converter.md
BCD_XS3_CONVERTER -- requirements
Module: bcd_xs3_converter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of 4-bit digits per word (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request carries a valid word.
REQ-005 SHALL have port in_ready  output  1  converter can accept a word.
REQ-006 SHALL have port mode  input  1  conversion direction: 0 = BCD->excess-3 (add 3), 1 = excess-3->BCD (subtract 3); sampled with the input word.
REQ-007 SHALL have port in_data  input  4*DIGITS  packed digits; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-008 SHALL have port out_valid  output  1  result word available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_data  output  4*DIGITS  converted digits, same packing as in_data.
REQ-011 SHALL have port out_err_mask  output  DIGITS  bit i set if source digit i was not a legal code for the sampled mode.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CONVERT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; a word is accepted on a rising edge with in_valid && in_ready.
REQ-015 SHALL on acceptance latch in_data and mode, clear out_err_mask, set digit index to 0, and enter CONVERT.
REQ-016 SHALL in CONVERT process exactly one digit per cycle, digit 0 first, through a single shared 4-bit add/subtract unit.
REQ-017 SHALL compute each result digit modulo 16 (digit + 3 for mode 0; digit - 3, two's-complement, carry discarded, for mode 1).
REQ-018 SHALL flag digit i as illegal when mode 0 and digit > 9, or mode 1 and (digit < 3 or digit > 12); the modular result is still written.
REQ-019 SHALL move from CONVERT to DONE on the edge that processes digit DIGITS-1, so out_valid rises exactly DIGITS edges after the accepting edge.
REQ-020 SHALL in DONE hold out_valid = 1, with out_data and out_err_mask stable, until out_valid && out_ready.
REQ-021 SHALL return to IDLE on the handshake edge; in_ready is 1 in the following cycle (no same-cycle turnaround).
REQ-022 SHALL ignore in_valid, in_data and mode outside IDLE.
REQ-023 SHALL keep out_data and out_err_mask at last result values in IDLE; they are only meaningful while out_valid = 1.
REQ-024 SHALL support DIGITS = 1: CONVERT lasts one cycle; the index counter is at least 1 bit wide.

Reset
REQ-025 SHALL on rst_n low immediately force FSM to IDLE, in_ready = 1 after release, out_valid = 0, busy = 0, out_data = 0, out_err_mask = 0, index = 0.
REQ-026 SHALL abort any in-flight word on reset mid-CONVERT or mid-DONE with no partial result presented afterwards.

Structure
REQ-027 SHALL place the FSM state type, the XS3_OFFSET constant (4'd3) and the mode encodings (MODE_TO_XS3 = 0, MODE_TO_BCD = 1) in shared package bcd_xs3_pkg.
REQ-028 SHALL instantiate one combinational sub-module digit_addsub (4-bit operands, subtract control, 4-bit result, carry out) as the only arithmetic datapath.
REQ-029 SHALL use a shift register over the latched word, shifting down one digit per cycle, or an equivalent indexed write; no DIGITS-wide parallel adders.

Verification (DIGITS = 4)
REQ-030 SHALL cover: mode 0, in_data 16'h1234 accepted at edge 0 -> out_valid at edge 4, out_data 16'h4567, mask 4'b0000.
REQ-031 SHALL cover: mode 1, in_data 16'h4567 -> out_data 16'h1234, mask 4'b0000.
REQ-032 SHALL cover: mode 0, in_data 16'h19A0 -> out_data 16'h4CD3, mask 4'b0010.
REQ-033 SHALL cover: mode 1, in_data 16'h0F33 -> out_data 16'hDC00, mask 4'b1100.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE with in_valid toggling -> out_data stable, in_ready 0, no new word accepted; in_ready 1 the cycle after the handshake.
REQ-035 SHALL cover: rst_n pulsed low at CONVERT index 2 -> outputs zero at once, busy 0; the next word 16'h0000 in mode 0 yields 16'h3333.
